fifo_flags: RTL and testbench



---
 rtl/fifo_flags.sv | 113 +++++++++++
 tb/tb_fifo_flags.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky error flags, synchronous flush and optional FWFT read mode.
module fifo_flags #(
    parameter int WORD_BITS     = 8,
    parameter int ADDR_BITS     = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDR_BITS-2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 write_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic                 read_i,
    output logic [WORD_BITS-1:0] rdata_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_empty_o,
    output logic                 almost_full_o,
    output logic [ADDR_BITS:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AFULL_THRESH);
    localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS+1)'(AEMPTY_THRESH);

    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_flags: AFULL_THRESH outside 0..depth");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("fifo_flags: AEMPTY_THRESH outside 0..depth");
    end

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wptr;
    logic [ADDR_BITS-1:0] rptr;
    logic [ADDR_BITS:0]   count;
    logic                 ovf;
    logic                 udf;
    logic                 rd_ok;
    logic                 wr_ok;

    assign empty_o        = (count == '0);
    assign full_o         = (count == DEPTH_C);
    assign almost_empty_o = (count <= AE_C);
    assign almost_full_o  = (count >= AF_C);
    assign count_o        = count;
    assign overflow_o     = ovf;
    assign underflow_o    = udf;

    // A pop in the same cycle frees the slot a write at full needs
    assign rd_ok = read_i && !empty_o;
    assign wr_ok = write_i && (!full_o || rd_ok);

    always_ff @(posedge clk_i) begin
        if (wr_ok && !clear_i) begin
            mem[wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (write_i && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (read_i && !rd_ok) begin
                udf <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata_o = mem[rptr];
    end else begin : g_reg
        logic [WORD_BITS-1:0] rdata_q;
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                rdata_q <= '0;
            end else if (!clear_i && rd_ok) begin
                rdata_q <= mem[rptr];
            end
        end
        assign rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: registered-read and FWFT instances.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       c0, w0, r0;
    logic [7:0] wd0;
    logic [7:0] rd0;
    logic       e0, f0, ae0, af0, ov0, un0;
    logic [4:0] cnt0;
    logic       c1, w1, r1;
    logic [7:0] wd1;
    logic [7:0] rd1;
    logic       e1, f1, ae1, af1, ov1, un1;
    logic [4:0] cnt1;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    fifo_flags #(.FWFT(0)) u0 (
        .clk_i(clk), .reset_i(reset_i), .clear_i(c0),
        .write_i(w0), .wdata_i(wd0), .read_i(r0), .rdata_o(rd0),
        .empty_o(e0), .full_o(f0), .almost_empty_o(ae0),
        .almost_full_o(af0), .count_o(cnt0),
        .overflow_o(ov0), .underflow_o(un0)
    );

    fifo_flags #(.FWFT(1)) u1 (
        .clk_i(clk), .reset_i(reset_i), .clear_i(c1),
        .write_i(w1), .wdata_i(wd1), .read_i(r1), .rdata_o(rd1),
        .empty_o(e1), .full_o(f1), .almost_empty_o(ae1),
        .almost_full_o(af1), .count_o(cnt1),
        .overflow_o(ov1), .underflow_o(un1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        {c0, w0, r0, c1, w1, r1} = '0;
        wd0 = '0;
        wd1 = '0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;

        // reset state
        chk("rst_empty", 32'(e0), 1);
        chk("rst_full", 32'(f0), 0);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_aempty", 32'(ae0), 1);
        chk("rst_afull", 32'(af0), 0);
        chk("rst_ovf", 32'(ov0), 0);
        chk("rst_udf", 32'(un0), 0);
        chk("rst_rdata", 32'(rd0), 0);
        chk("rst_empty1", 32'(e1), 1);

        // fill 1..16
        for (int i = 1; i <= 16; i++) begin
            w0 = 1'b1;
            wd0 = 8'(i);
            tick;
            chk("fill_count", 32'(cnt0), 32'(i));
            chk("fill_aempty", 32'(ae0), (i <= 2) ? 1 : 0);
            chk("fill_afull", 32'(af0), (i >= 14) ? 1 : 0);
            chk("fill_full", 32'(f0), (i == 16) ? 1 : 0);
        end

        // overflow
        wd0 = 8'd17;
        tick;
        w0 = 1'b0;
        chk("ovf_count", 32'(cnt0), 16);
        chk("ovf_flag", 32'(ov0), 1);
        tick;
        chk("ovf_sticky", 32'(ov0), 1);

        // drain 1..16
        for (int i = 1; i <= 16; i++) begin
            r0 = 1'b1;
            tick;
            chk("drain_data", 32'(rd0), 32'(i));
            chk("drain_count", 32'(cnt0), 32'(16 - i));
        end
        r0 = 1'b0;
        chk("drain_empty", 32'(e0), 1);
        chk("drain_ovf_kept", 32'(ov0), 1);

        // underflow
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        chk("udf_hold", 32'(rd0), 16);
        chk("udf_flag", 32'(un0), 1);
        chk("udf_count", 32'(cnt0), 0);
        tick;
        chk("udf_sticky", 32'(un0), 1);

        // clear
        c0 = 1'b1;
        tick;
        c0 = 1'b0;
        chk("clr_ovf", 32'(ov0), 0);
        chk("clr_udf", 32'(un0), 0);
        chk("clr_rdata_hold", 32'(rd0), 16);
        chk("clr_empty", 32'(e0), 1);

        // write 16, read 8, write 8, then read+write at full
        for (int i = 0; i < 16; i++) begin
            w0 = 1'b1;
            wd0 = 8'(8'h20 + i);
            q.push_back(wd0);
            tick;
        end
        w0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r0 = 1'b1;
            tick;
            chk("wrap_rd8", 32'(rd0), 32'(q.pop_front()));
        end
        r0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w0 = 1'b1;
            wd0 = 8'(8'h30 + i);
            q.push_back(wd0);
            tick;
        end
        chk("wrap_full", 32'(f0), 1);
        for (int i = 0; i < 4; i++) begin
            w0 = 1'b1;
            r0 = 1'b1;
            wd0 = 8'(8'h40 + i);
            q.push_back(wd0);
            tick;
            chk("rw_full_data", 32'(rd0), 32'(q.pop_front()));
            chk("rw_full_count", 32'(cnt0), 16);
        end
        w0 = 1'b0;
        chk("rw_full_noovf", 32'(ov0), 0);
        for (int i = 0; i < 16; i++) begin
            r0 = 1'b1;
            tick;
            chk("wrap_drain", 32'(rd0), 32'(q.pop_front()));
        end
        r0 = 1'b0;
        chk("wrap_empty", 32'(e0), 1);
        chk("wrap_hand_last", 32'(rd0), 32'h43);

        // read+write on empty: write lands, read rejected
        w0 = 1'b1;
        r0 = 1'b1;
        wd0 = 8'h55;
        tick;
        w0 = 1'b0;
        r0 = 1'b0;
        chk("rwe_count", 32'(cnt0), 1);
        chk("rwe_udf", 32'(un0), 1);
        chk("rwe_rdata_hold", 32'(rd0), 32'h43);
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        chk("rwe_data", 32'(rd0), 32'h55);

        // mid-stream clear discards queued data
        for (int i = 0; i < 3; i++) begin
            w0 = 1'b1;
            wd0 = 8'(8'h60 + i);
            tick;
        end
        w0 = 1'b0;
        c0 = 1'b1;
        tick;
        c0 = 1'b0;
        chk("mclr_count", 32'(cnt0), 0);
        chk("mclr_udf", 32'(un0), 0);
        w0 = 1'b1;
        wd0 = 8'h66;
        tick;
        w0 = 1'b0;
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        chk("mclr_fresh", 32'(rd0), 32'h66);
        chk("mclr_empty", 32'(e0), 1);

        // FWFT instance
        w1 = 1'b1;
        wd1 = 8'hA5;
        tick;
        w1 = 1'b0;
        chk("fwft_first", 32'(rd1), 32'hA5);
        chk("fwft_count1", 32'(cnt1), 1);
        w1 = 1'b1;
        wd1 = 8'h3C;
        tick;
        w1 = 1'b0;
        chk("fwft_head_kept", 32'(rd1), 32'hA5);
        r1 = 1'b1;
        tick;
        r1 = 1'b0;
        chk("fwft_next", 32'(rd1), 32'h3C);
        chk("fwft_count2", 32'(cnt1), 1);
        c1 = 1'b1;
        w1 = 1'b1;
        wd1 = 8'h77;
        tick;
        c1 = 1'b0;
        w1 = 1'b0;
        chk("fwft_clr_count", 32'(cnt1), 0);
        chk("fwft_clr_empty", 32'(e1), 1);
        w1 = 1'b1;
        wd1 = 8'h11;
        tick;
        w1 = 1'b0;
        chk("fwft_after_clr", 32'(rd1), 32'h11);
        chk("fwft_after_cnt", 32'(cnt1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
